// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU MEM stage and a word-only data memory.
// Optional macro MISALIGN_TRAP_EN: flag misaligned half/word ops on err_o and suppress them.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              ready_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MERGE_WR = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              op_we_q, op_we_d;
    logic              op_uns_q, op_uns_d;
    logic              op_mis_q, op_mis_d;
    logic [1:0]        op_size_q, op_size_d;
    logic [1:0]        op_lane_q, op_lane_d;
    logic [15:0]       op_wdata_q, op_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              mem_wr_d;
    logic [31:0]       mem_wdata_d;
    logic [31:0]       rdata_d;
    logic              req_mis;

    function automatic logic [31:0] load_ext(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic [1:0]  lane,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        r = w;
        unique case (1'b1)
            sz[1]:          r = w;
            (sz == 2'b01):  r = {{16{h[15] & ~uns}}, h};
            (sz == 2'b00):  r = {{24{b[7] & ~uns}}, b};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_lane(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic [1:0]  lane,
        input logic [15:0] wd
    );
        logic [31:0] r;
        r = w;
        if (sz == 2'b01) begin
            r[{lane[1], 4'b0000} +: 16] = wd;
        end else begin
            r[{lane, 3'b000} +: 8] = wd[7:0];
        end
        return r;
    endfunction

`ifdef MISALIGN_TRAP_EN
    assign req_mis = ((size_i == 2'b01) && addr_i[0]) ||
                     (size_i[1] && (addr_i[1:0] != 2'b00));
    assign err_o   = done_o & op_mis_q;
`else
    assign req_mis = 1'b0;
    assign err_o   = 1'b0;
`endif

    assign ready_o = (state_q == IDLE);
    assign done_o  = (state_q == RESP);

    // State and datapath registers; memory-side outputs are flop-driven.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            op_we_q     <= 1'b0;
            op_uns_q    <= 1'b0;
            op_mis_q    <= 1'b0;
            op_size_q   <= 2'b00;
            op_lane_q   <= 2'b00;
            op_wdata_q  <= '0;
            mem_addr_o  <= '0;
            mem_wr_o    <= 1'b0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
        end else begin
            state_q     <= state_d;
            op_we_q     <= op_we_d;
            op_uns_q    <= op_uns_d;
            op_mis_q    <= op_mis_d;
            op_size_q   <= op_size_d;
            op_lane_q   <= op_lane_d;
            op_wdata_q  <= op_wdata_d;
            mem_addr_o  <= mem_addr_d;
            mem_wr_o    <= mem_wr_d;
            mem_wdata_o <= mem_wdata_d;
            rdata_o     <= rdata_d;
        end
    end

    // Next-state and next-datapath logic; write strobe defaults low.
    always_comb begin
        state_d     = state_q;
        op_we_d     = op_we_q;
        op_uns_d    = op_uns_q;
        op_mis_d    = op_mis_q;
        op_size_d   = op_size_q;
        op_lane_d   = op_lane_q;
        op_wdata_d  = op_wdata_q;
        mem_addr_d  = mem_addr_o;
        mem_wr_d    = 1'b0;
        mem_wdata_d = mem_wdata_o;
        rdata_d     = rdata_o;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    op_we_d    = we_i;
                    op_uns_d   = unsigned_i;
                    op_mis_d   = req_mis;
                    op_size_d  = size_i;
                    op_lane_d  = addr_i[1:0];
                    op_wdata_d = wdata_i[15:0];
                    mem_addr_d = {addr_i[ADDR_W-1:2], 2'b00};
                    if (we_i && size_i[1] && !req_mis) begin
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = wdata_i;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!op_mis_q) begin
                    if (!op_we_q) begin
                        rdata_d = load_ext(mem_rdata_i, op_size_q,
                                           op_lane_q, op_uns_q);
                    end else if (!op_size_q[1]) begin
                        mem_wdata_d = merge_lane(mem_rdata_i, op_size_q,
                                                 op_lane_q, op_wdata_q);
                        mem_wr_d    = 1'b1;
                        state_d     = MERGE_WR;
                    end
                end
            end
            MERGE_WR: state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a word memory and
// a byte-level reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, done, err, mem_wr;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram [64];
    logic        ram_ready = 1'b0;
    logic [7:0]  ref_mem [256];
    logic [31:0] ref_rdata = '0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we),
        .size_i(size), .unsigned_i(uns), .addr_i(addr),
        .wdata_i(wdata), .ready_o(ready), .done_o(done),
        .rdata_o(rdata), .err_o(err), .mem_addr_o(mem_addr),
        .mem_wr_o(mem_wr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h0000_1357;
    endfunction

    // Word memory: combinational read, write on the falling edge.
    assign mem_rdata = ram[mem_addr[7:2]];
    always @(negedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (mem_wr) begin
            ram[mem_addr[7:2]] <= mem_wdata;
        end
    end

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_mis(logic [1:0] sz, int a);
`ifdef MISALIGN_TRAP_EN
        return (a % nbytes(sz)) != 0 && sz != 2'd0;
`else
        return (sz == 2'd7) && (a < 0);
`endif
    endfunction

    function automatic logic [31:0] model_load(logic [1:0] sz, logic u, int a);
        int n;
        int ea;
        longint v;
        n = nbytes(sz);
        ea = a - (a % n);
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[ea + i]) << (8 * i);
        if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v + (longint'(1) << 32) - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic void model_store(logic [1:0] sz, int a, logic [31:0] d);
        int n;
        int ea;
        logic [31:0] dv;
        if (model_mis(sz, a)) return;
        n = nbytes(sz);
        ea = a - (a % n);
        dv = d;
        for (int i = 0; i < n; i++) ref_mem[ea + i] = dv[8*i +: 8];
    endfunction

    function automatic logic [31:0] ref_word(int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    // Issue one op; returns cycles from request cycle to done cycle inclusive.
    task automatic run_op(input logic w, input logic [1:0] sz, input logic u,
                          input int a, input logic [31:0] d,
                          output int cyc, output int wrs,
                          output logic e, output logic [31:0] rd);
        int g;
        we = w; size = sz; uns = u; addr = 32'(a); wdata = d; req = 1'b1;
        g = 0;
        while (!ready && g < 20) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        req = 1'b0;
        cyc = 2; wrs = 0;
        while (!done && cyc < 12) begin
            if (mem_wr) wrs++;
            @(posedge clk); #1;
            cyc++;
        end
        e = err; rd = rdata;
        if (!done) begin
            errors++;
            $display("FAIL timeout: done_o not seen after %0d cycles", cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ready, done, err, mem_wr} !== 4'b1000 || rdata !== 0 ||
            mem_addr !== 0 || mem_wdata !== 0) begin
            errors++;
            $display("FAIL reset_idle: rdy=%b dn=%b er=%b wr=%b rd=%h ad=%h wd=%h",
                     ready, done, err, mem_wr, rdata, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_rmw;
        int wrs;
        wrs = 0;
        we = 1'b1; size = 2'd0; uns = 1'b0; addr = 32'h31; wdata = 32'h77;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin
            if (mem_wr) wrs++;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        checks++;
        if ({ready, done, err, mem_wr} !== 4'b1000 || rdata !== 0 ||
            mem_addr !== 0 || mem_wdata !== 0 || wrs != 0) begin
            errors++;
            $display("FAIL reset_mid_rmw: rdy=%b dn=%b wr=%b ad=%h wd=%h wrs=%0d need idle/0",
                     ready, done, mem_wr, mem_addr, mem_wdata, wrs);
        end
        @(negedge clk); #1;
        checks++;
        if (ram[12] !== ref_word(12)) begin
            errors++;
            $display("FAIL reset_no_write: word=%h need %h", ram[12], ref_word(12));
        end
    endtask

    task automatic test_word;
        int c, w; logic e; logic [31:0] rd;
        run_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, c, w, e, rd);
        model_store(2'd2, 32'h10, 32'hDEAD_BEEF);
        checks++;
        if (c != 3 || w != 1) begin
            errors++;
            $display("FAIL sw_timing: cycles=%0d writes=%0d need 3/1", c, w);
        end
        run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, c, w, e, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF || c != 3 || w != 0) begin
            errors++;
            $display("FAIL lw: rdata=%h cyc=%0d wr=%0d need DEADBEEF/3/0", rd, c, w);
        end
        ref_rdata = rd;
        checks++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: done=%b ready=%b need 0/1", done, ready);
        end
    endtask

    task automatic test_sb;
        int c, w; logic e; logic [31:0] rd;
        run_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, c, w, e, rd);
        model_store(2'd2, 32'h20, 32'h1122_3344);
        run_op(1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFF_FFA5, c, w, e, rd);
        model_store(2'd0, 32'h21, 32'hFFFF_FFA5);
        checks++;
        if (c != 4 || w != 1) begin
            errors++;
            $display("FAIL sb_timing: cycles=%0d writes=%0d need 4/1", c, w);
        end
        checks++;
        if (rd !== ref_rdata) begin
            errors++;
            $display("FAIL sb_rdata_hold: rdata=%h need %h", rd, ref_rdata);
        end
        run_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, c, w, e, rd);
        checks++;
        if (rd !== 32'h1122_A544 || rd !== model_load(2'd2, 1'b0, 32'h20)) begin
            errors++;
            $display("FAIL sb_merge: rdata=%h need 1122A544", rd);
        end
        ref_rdata = rd;
    endtask

    task automatic test_sh;
        int c, w; logic e; logic [31:0] rd;
        run_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, c, w, e, rd);
        model_store(2'd2, 32'h20, 32'h1122_3344);
        run_op(1'b1, 2'd1, 1'b0, 32'h22, 32'h5555_8001, c, w, e, rd);
        model_store(2'd1, 32'h22, 32'h5555_8001);
        run_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, c, w, e, rd);
        checks++;
        if (rd !== 32'h8001_3344) begin
            errors++;
            $display("FAIL sh_merge: rdata=%h need 80013344", rd);
        end
        run_op(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, c, w, e, rd);
        checks++;
        if (rd !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL lh: rdata=%h need FFFF8001", rd);
        end
        run_op(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, c, w, e, rd);
        checks++;
        if (rd !== 32'h0000_8001) begin
            errors++;
            $display("FAIL lhu: rdata=%h need 00008001", rd);
        end
        ref_rdata = rd;
    endtask

    task automatic test_lb;
        int c, w; logic e; logic [31:0] rd;
        run_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF_0000, c, w, e, rd);
        model_store(2'd2, 32'h20, 32'h80FF_0000);
        run_op(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, c, w, e, rd);
        checks++;
        if (rd !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb: rdata=%h need FFFFFF80", rd);
        end
        run_op(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, c, w, e, rd);
        checks++;
        if (rd !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu: rdata=%h need 00000080", rd);
        end
        ref_rdata = rd;
    endtask

    // req_i held high: a word load completes every 3 cycles, one accept each.
    task automatic test_back_to_back;
        int acc, dn, bad;
        logic [31:0] exp;
        exp = model_load(2'd2, 1'b0, 32'h10);
        acc = 0; dn = 0; bad = 0;
        we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h10; req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (ready) acc++;
            @(posedge clk); #1;
            if (done) begin
                dn++;
                if (rdata !== exp) bad++;
            end
        end
        req = 1'b0;
        checks++;
        if (acc != 4 || dn != 4 || bad != 0) begin
            errors++;
            $display("FAIL back_to_back: accepts=%0d dones=%0d bad=%0d need 4/4/0",
                     acc, dn, bad);
        end
        ref_rdata = exp;
    endtask

    task automatic test_misalign;
        int c, w; logic e; logic [31:0] rd;
        logic exp_e;
        exp_e = model_mis(2'd2, 32'h12);
        run_op(1'b1, 2'd2, 1'b0, 32'h12, 32'hCAFE_F00D, c, w, e, rd);
        model_store(2'd2, 32'h12, 32'hCAFE_F00D);
        @(negedge clk); #1;
        checks++;
        if (e !== exp_e || c != 3 || w != (exp_e ? 0 : 1)) begin
            errors++;
            $display("FAIL misalign_sw: err=%b cyc=%0d wr=%0d need err=%b",
                     e, c, w, exp_e);
        end
        checks++;
        if (ram[4] !== ref_word(4)) begin
            errors++;
            $display("FAIL misalign_word: word=%h need %h", ram[4], ref_word(4));
        end
    endtask

    task automatic test_random;
        int c, w, a, bad;
        logic e, op_we, u, mis;
        logic [1:0] sz;
        logic [31:0] d, rd, exp;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            op_we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            u = 1'($urandom_range(0, 1));
            a = int'($urandom_range(0, 255));
            d = $urandom;
            mis = model_mis(sz, a);
            exp = (op_we || mis) ? ref_rdata : model_load(sz, u, a);
            run_op(op_we, sz, u, a, d, c, w, e, rd);
            if (op_we) model_store(sz, a, d);
            ref_rdata = exp;
            checks++;
            if (rd !== exp || e !== mis ||
                c != ((op_we && !sz[1] && !mis) ? 4 : 3) ||
                w != ((op_we && !mis) ? 1 : 0)) begin
                errors++;
                bad++;
                if (bad < 8)
                    $display("FAIL random_op%0d: we=%b sz=%0d a=%h rd=%h need %h err=%b cyc=%0d wr=%0d",
                             i, op_we, sz, a, rd, exp, e, c, w);
            end
        end
        @(negedge clk); #1;
        bad = 0;
        for (int i = 0; i < 64; i++) if (ram[i] !== ref_word(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL memory_image: %0d words differ from model", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            logic [31:0] v;
            v = init_word(i);
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = v[8*k +: 8];
        end
        test_reset;
        @(posedge clk); #1;
        test_reset_mid_rmw;
        test_word;
        test_sb;
        test_sh;
        test_lb;
        test_back_to_back;
        test_misalign;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
